// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline control blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        HALT,
        STEP
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned MDU_LAT_DEFAULT = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signals between the pipeline datapath and the sequencing controller.
interface pipeline_ctrl_if #(
    parameter int unsigned STALL_W = 16
);
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rt;
    logic               id_mdu_op;
    logic               ex_memread;
    logic [4:0]         ex_rt;
    logic               branch_taken;
    logic               halt_req;
    logic               step_req;
    logic               pc_we;
    logic               ifid_le;
    logic               ifid_enable;
    logic               ifid_clear;
    logic               idex_flush;
    logic               mdu_busy;
    logic               halted;
    logic [STALL_W-1:0] stall_cycles;

    // Controller side.
    modport master (
        input  id_rs, id_rt, id_uses_rt, id_mdu_op, ex_memread, ex_rt,
        input  branch_taken, halt_req, step_req,
        output pc_we, ifid_le, ifid_enable, ifid_clear, idex_flush,
        output mdu_busy, halted, stall_cycles
    );

    // Datapath side.
    modport slave (
        output id_rs, id_rt, id_uses_rt, id_mdu_op, ex_memread, ex_rt,
        output branch_taken, halt_req, step_req,
        input  pc_we, ifid_le, ifid_enable, ifid_clear, idex_flush,
        input  mdu_busy, halted, stall_cycles
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of ID.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);

    always_comb begin
        lu = ex_memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, MDU wait and
// debug halt/step. Outputs are decoded combinationally from state and inputs.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
    parameter int unsigned STALL_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    pipeline_ctrl_if.master bus
);

    ctrl_state_t        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q;
    logic               lu;

    logic pc_we, ifid_enable, ifid_clear, idex_flush, mdu_busy, halted;

    hazard_detect u_hazard_detect (
        .ex_memread (bus.ex_memread),
        .ex_rt      (bus.ex_rt),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .lu         (lu)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b0;
        ifid_enable = 1'b0;
        ifid_clear  = 1'b0;
        idex_flush  = 1'b1;
        mdu_busy    = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            RUN, STEP: begin
                // A step cycle falls back to HALT unless it launches an MDU op.
                if (state_q == STEP) begin
                    state_d = HALT;
                end
                if (bus.branch_taken) begin
                    pc_we       = 1'b1;
                    ifid_enable = 1'b1;
                    ifid_clear  = 1'b1;
                end else if (!lu) begin
                    pc_we       = 1'b1;
                    ifid_enable = 1'b1;
                    idex_flush  = 1'b0;
                    if (bus.id_mdu_op) begin
                        state_d = MDU_WAIT;
                        cnt_d   = 8'(MDU_LAT - 1);
                    end else if (state_q == RUN && bus.halt_req) begin
                        state_d = HALT;
                    end
                end
            end
            MDU_WAIT: begin
                mdu_busy = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (!bus.halt_req) begin
                    state_d = RUN;
                end else if (bus.step_req) begin
                    state_d = STEP;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset forces every control output low without waiting for a clock.
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_enable = 1'b0;
            ifid_clear  = 1'b0;
            idex_flush  = 1'b0;
            mdu_busy    = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_we && (stall_q != {STALL_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_le      = rst_n;
    assign bus.ifid_enable  = ifid_enable;
    assign bus.ifid_clear   = ifid_clear;
    assign bus.idex_flush   = idex_flush;
    assign bus.mdu_busy     = mdu_busy;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded bench for pipeline_ctrl: directed scenarios then random traffic.
module tb_pipeline_ctrl;

    localparam int unsigned LAT = 4;
    localparam int unsigned SW  = 4;
    localparam int          SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.STALL_W(SW)) bus ();

    pipeline_ctrl #(
        .MDU_LAT (LAT),
        .STALL_W (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          pc_we;
        logic          le;
        logic          en;
        logic          clr;
        logic          fl;
        logic          busy;
        logic          hlt;
        logic [SW-1:0] sc;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model: cycles of MDU wait left, halted/stepping flags, stall count.
    int m_wait   = 0;
    bit m_halted = 1'b0;
    bit m_step   = 1'b0;
    int m_cnt    = 0;

    function automatic exp_t act(input exp_t base, input bit pc, input bit en,
                                 input bit clr, input bit fl);
        exp_t r;
        r       = base;
        r.pc_we = pc;
        r.en    = en;
        r.clr   = clr;
        r.fl    = fl;
        return r;
    endfunction

    task automatic cycle(input string tag, input bit rst, input bit br, input bit mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                         input bit ur, input bit um, input bit hr, input bit sr);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n            = rst;
        bus.branch_taken = br;
        bus.ex_memread   = mr;
        bus.ex_rt        = ert;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rt   = ur;
        bus.id_mdu_op    = um;
        bus.halt_req     = hr;
        bus.step_req     = sr;
        e = '0;
        if (!rst) begin
            m_wait   = 0;
            m_halted = 1'b0;
            m_step   = 1'b0;
            m_cnt    = 0;
        end else begin
            lu     = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
            e.le   = 1'b1;
            e.sc   = SW'(m_cnt);
            e.busy = (m_wait > 0);
            e.hlt  = m_halted && !m_step && (m_wait == 0);
            if (m_wait > 0) begin
                e = act(e, 0, 0, 0, 1);
                m_wait--;
            end else if (m_halted && !m_step) begin
                e = act(e, 0, 0, 0, 1);
                if (!hr) m_halted = 1'b0;
                else if (sr) m_step = 1'b1;
            end else begin
                if (br) begin
                    e = act(e, 1, 1, 1, 1);
                end else if (lu) begin
                    e = act(e, 0, 0, 0, 1);
                end else begin
                    e = act(e, 1, 1, 0, 0);
                    if (um) begin
                        m_wait   = LAT;
                        m_halted = 1'b0;
                    end else if (hr && !m_step) begin
                        m_halted = 1'b1;
                    end
                end
                m_step = 1'b0;
            end
            if (!e.pc_we && m_cnt < SAT) m_cnt++;
        end
        expq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic idle(input string tag, input bit hr);
        cycle(tag, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, hr, 0);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        exp_t  got;
        string tag;
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            tag = tagq.pop_front();
            got = {bus.pc_we, bus.ifid_le, bus.ifid_enable, bus.ifid_clear, bus.idex_flush,
                   bus.mdu_busy, bus.halted, bus.stall_cycles};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got pc_we/le/en/clr/fl/busy/hlt=%b%b%b%b%b%b%b sc=%0d, expected %b%b%b%b%b%b%b sc=%0d",
                         tag, got.pc_we, got.le, got.en, got.clr, got.fl, got.busy, got.hlt,
                         got.sc, e.pc_we, e.le, e.en, e.clr, e.fl, e.busy, e.hlt, e.sc);
            end
        end
    end

    initial begin
        bit hr;
        bit rst;
        rst_n            = 1'b0;
        bus.branch_taken = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.id_mdu_op    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.step_req     = 1'b0;

        cycle("reset", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle("reset", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        idle("first_run", 0);

        cycle("lu_rs", 1, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0);
        idle("after_lu", 0);
        cycle("lu_zero", 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        cycle("lu_rt", 1, 0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0, 0);
        cycle("no_lu_rt_unused", 1, 0, 1, 5'd9, 5'd2, 5'd9, 0, 0, 0, 0);
        cycle("branch_over_lu", 1, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
        idle("after_branch", 0);

        cycle("mdu_issue", 1, 0, 0, 5'd0, 5'd1, 5'd2, 1, 1, 0, 0);
        repeat (LAT) idle("mdu_wait", 0);
        idle("mdu_done", 0);

        idle("halt_enter", 1);
        repeat (2) idle("halted", 1);
        cycle("step_req", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        idle("step_cycle", 1);
        idle("halted_again", 1);
        cycle("step_vs_resume", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        idle("resumed", 0);

        cycle("mdu_then_halt", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        repeat (LAT) idle("mdu_halt_deferred", 1);
        idle("run_before_halt", 1);
        idle("halt_after_mdu", 1);
        idle("release_halt", 0);
        idle("run", 0);

        cycle("mdu_for_reset", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        idle("mdu_wait", 0);
        cycle("reset_mid_mdu", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        idle("after_reset", 0);

        repeat (SAT + 5) cycle("saturate", 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0);
        idle("sat_hold", 0);

        hr  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) hr = ~hr;
            if (rst) rst = ($urandom_range(199) != 0);
            else     rst = ($urandom_range(2) == 0);
            cycle("random", rst,
                  (m_wait == 0) && ($urandom_range(9) == 0),
                  $urandom_range(3) == 0,
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  $urandom_range(1) == 1,
                  $urandom_range(9) == 0,
                  hr,
                  $urandom_range(4) == 0);
        end

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the IF/ID register controls (`le`, `enable`, `clear`), the PC write enable and the ID/EX bubble insert. It resolves load-use stalls, taken-branch flushes, multi-cycle MDU (mult/div) waits and debug halt/single-step. It sits beside the hazard/forwarding logic and is the only source of stall and flush in the core.

## Interface
- `MDU_LAT`, 32: MDU busy cycles after a mult/div leaves ID; legal range 2..255.
- `STALL_W`, 16: width of the stall-cycle performance counter.
---
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt.
- `id_mdu_op` in 1: ID instruction is mult/multu/div/divu.
- `ex_memread` in 1: EX instruction is a load.
- `ex_rt` in 5: load destination register in EX.
- `branch_taken` in 1: taken branch/jump resolved this cycle.
- `halt_req` in 1: debug halt request, level-sensitive.
- `step_req` in 1: debug single-step, one-cycle pulse.
- `pc_we` out 1: PC update enable.
- `ifid_le`, `ifid_enable`, `ifid_clear` out 1: IF/ID register controls. The register loads when `le & enable`, and loads zero when `clear` is also set.
- `idex_flush` out 1: inject a bubble into ID/EX.
- `mdu_busy`, `halted` out 1: state flags.
- `stall_cycles` out STALL_W: saturating count of cycles with `pc_we=0` while `rst_n` is high.

## Operation
- States (package enum): RUN, MDU_WAIT, HALT, STEP.
- Reset values (`rst_n` low): state RUN, MDU counter 0, `stall_cycles` 0. All outputs are 0, including `ifid_le`.
- `ifid_le` is 1 whenever `rst_n` is high.
- Outputs are combinational (Mealy) from the state plus the current inputs. State and counters are registered.
- Load-use hazard `lu` = `ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`.
- Priority within a cycle, highest first: `branch_taken` > `lu` > MDU > halt.
- Flush action: `pc_we=1`, `ifid_enable=1`, `ifid_clear=1`, `idex_flush=1`.
- Stall action: `pc_we=0`, `ifid_enable=0`, `ifid_clear=0`, `idex_flush=1`.
- Advance action: `pc_we=1`, `ifid_enable=1`, `ifid_clear=0`, `idex_flush=0`.
- RUN:
  - `branch_taken` → flush, stay in RUN. A wrong-path `id_mdu_op` or `lu` is ignored.
  - Else `lu` → stall, stay in RUN.
  - Else `id_mdu_op` → advance; next state MDU_WAIT with counter = MDU_LAT-1.
  - Else `halt_req` → advance; next state HALT.
  - Else → advance.
- MDU_WAIT:
  - Stall every cycle. Counter decrements each cycle; at 0, next state RUN.
  - `halt_req` is deferred until RUN.
  - `branch_taken` cannot occur here, because EX holds a bubble.
- HALT:
  - Stall, `halted=1`.
  - `halt_req` low → RUN.
  - Else `step_req` → STEP.
  - `step_req` arriving together with `halt_req` low: RUN wins.
- STEP:
  - Exactly one cycle with the RUN rules applied.
  - Next state is HALT, unless `id_mdu_op` advanced, in which case MDU_WAIT; it returns to RUN or HALT afterwards per `halt_req`.
- `stall_cycles` saturates at all-ones and never wraps.

## Timing
- Stall and flush take effect in the same cycle the condition is present (zero latency).
- Load-use stall lasts exactly 1 cycle, since the load moves to MEM.
- An MDU op costs exactly MDU_LAT stall cycles, starting the cycle after it leaves ID.
- Halt takes effect the cycle after the first RUN cycle with `halt_req` high.
- A `rst_n` assertion mid-MDU_WAIT or mid-HALT forces RUN immediately and asynchronously. The first cycle after release is RUN.

## Structure
- Package `mips_pkg`:
  - `ctrl_state_t` enum.
  - `REG_ZERO` = 5'd0.
  - `MDU_LAT_DEFAULT`.
- Sub-module `hazard_detect`: purely combinational `lu` compare, reused later by the forwarding unit. The FSM, counters and output decode stay in `pipeline_ctrl`.

## Test plan
- Load-use: `ex_memread=1`, `ex_rt=8`, `id_rs=8` → one cycle with `pc_we=0`, `ifid_enable=0`, `idex_flush=1`; `stall_cycles` = 1. With `ex_rt=0` → no stall.
- Branch with hazard: `branch_taken=1` together with `lu=1` → `pc_we=1`, `ifid_clear=1`, `idex_flush=1`, and no stall count.
- MDU: `id_mdu_op=1` with MDU_LAT=4 → advance, then exactly 4 stall cycles with `mdu_busy=1`, then RUN; `stall_cycles` = 4.
- Debug: `halt_req=1` in RUN → HALT next cycle, `halted=1`. A `step_req` pulse → exactly one advance cycle, then back to HALT. `halt_req=0` → RUN.
- Halt during MDU: `halt_req` raised during MDU_WAIT with MDU_LAT=3 → HALT is reached only after the 3 stall cycles plus one RUN cycle.
- Reset: `rst_n` dropped asynchronously mid-MDU_WAIT → all outputs 0 and state RUN immediately; after release, advance on the first edge. Also check `stall_cycles` saturation with STALL_W=4 (15 holds at 15).
